// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
//
// Multiplexed 7-segment display driver. A packed hex word and per-digit
// decimal points are latched into a shadow register on a load strobe. A
// prescaler then time-multiplexes the shadow contents across DIGITS digits,
// with each digit enabled for CLK_DIV clocks. Nibbles are decoded to 0-F
// glyphs, and leading zeros can optionally be blanked.
//
// Parameters
//   DIGITS         number of scanned digits (1..8)
//   CLK_DIV        clocks each digit stays enabled (>= 1)
//   SEG_ACTIVE_LOW 1 = seg/dp pins are driven inverted
//   DIG_ACTIVE_LOW 1 = dig_sel pins are driven inverted
//
// Ports
//   clk      in   system clock; all state changes on the rising edge
//   rst_n    in   asynchronous active-low reset
//   load     in   single-cycle strobe that latches data_in/dp_in
//   data_in  in   packed nibbles; nibble i drives digit i (digit 0 = LSBs)
//   dp_in    in   decimal point per digit; bit i belongs to digit i
//   blank_lz in   1 = suppress leading zeros (sampled live, not latched)
//   seg      out  segments {g,f,e,d,c,b,a}
//   dp       out  decimal point of the active digit
//   dig_sel  out  one-hot digit enable
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int CLK_DIV        = 1000,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     dig_sel
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    // XOR masks applied at the output registers. Because "off" is all-zero
    // before inversion, these masks are also the reset (off) values.
    localparam logic [6:0]        SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_INV  = (SEG_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] DIG_INV = (DIG_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : '0;

    // State
    logic [CNT_W-1:0]    div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] shadow_data_q;
    logic [DIGITS-1:0]   shadow_dp_q;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   dig_sel_q, dig_sel_d;

    // Per-digit views of the shadow word
    logic [3:0]          nibble [DIGITS];
    logic [DIGITS-1:0]   blank;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Digit i is blank when every nibble from the top down to i is zero.
    // Digit 0 is never blanked, so a zero value still shows "0".
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nibble[gi] = shadow_data_q[4*gi +: 4];
            if (gi == 0) begin : g_first
                assign blank[gi] = 1'b0;
            end else begin : g_upper
                assign blank[gi] = blank_lz &&
                                   (shadow_data_q[4*DIGITS-1:4*gi] == '0);
            end
        end
    endgenerate

    // Prescaler and digit index
    always_comb begin
        div_cnt_d = div_cnt_q;
        idx_d     = idx_q;
        if (div_cnt_q == CNT_LAST) begin
            div_cnt_d = '0;
            idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    // Output next-state: decode, blank, then apply polarity last
    always_comb begin
        logic [DIGITS-1:0] one_hot;
        one_hot        = '0;
        one_hot[idx_q] = 1'b1;
        seg_d     = (blank[idx_q] ? 7'h00 : hex_to_seg(nibble[idx_q])) ^ SEG_INV;
        dp_d      = shadow_dp_q[idx_q] ^ DP_INV;
        dig_sel_d = one_hot ^ DIG_INV;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q     <= '0;
            idx_q         <= '0;
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            seg_q         <= SEG_INV;
            dp_q          <= DP_INV;
            dig_sel_q     <= DIG_INV;
        end else begin
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            dig_sel_q <= dig_sel_d;
            if (load) begin
                shadow_data_q <= data_in;
                shadow_dp_q   <= dp_in;
            end
        end
    end

    assign seg     = seg_q;
    assign dp      = dp_q;
    assign dig_sel = dig_sel_q;

endmodule
